// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame line levels and baud divisor helper.
// Used by both the receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int calc_baud_div(input int clk_freq, input int br);
    return clk_freq / br;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a history flop for start-edge detection.
// All flops reset to the idle line level, so no spurious edge is seen after reset.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic start_edge
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= LINE_IDLE;
      sync_reg <= LINE_IDLE;
      hist_reg <= LINE_IDLE;
    end else begin
      meta_reg <= rx;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign rx_s       = sync_reg;
  assign start_edge = (hist_reg == LINE_IDLE) && (sync_reg == LINE_START);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detection, mid-bit sampling, parity/stop checking, one-cycle valid pulse.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BR         = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_vld,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  rx_busy
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BR);
  localparam int HALF     = BAUD_DIV / 2;
  localparam int IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_RX_MAJORITY_EN
  // The vote completes one cycle after the nominal point; reloading the counter
  // with 1 instead of 0 keeps the sample grid at exactly BAUD_DIV cycles per bit.
  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam int LATE  = 1;
`else
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int LATE  = 0;
`endif

  localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF - 1 + LATE);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(BAUD_DIV - 1 + LATE);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(LATE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);

  logic rx_s;
  logic start_edge;
  logic sample_bit;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_reg <= {2{LINE_IDLE}};
    end else begin
      vote_reg <= {vote_reg[0], rx_s};
    end
  end

  assign sample_bit = (vote_reg[1] & vote_reg[0]) | (vote_reg[1] & rx_s) | (vote_reg[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  uart_state_t           state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  par_flag_reg, par_flag_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  vld_reg, vld_next;
  logic                  perr_reg, perr_next;
  logic                  ferr_reg, ferr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      par_flag_reg <= 1'b0;
      data_reg     <= '0;
      vld_reg      <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      par_flag_reg <= par_flag_next;
      data_reg     <= data_next;
      vld_reg      <= vld_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + 1'b1;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    par_flag_next = par_flag_reg;
    data_next     = data_reg;
    vld_next      = 1'b0;
    perr_next     = 1'b0;
    ferr_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start_edge) begin
          state_next    = START;
          par_flag_next = 1'b0;
        end
      end
      START: begin
        if (cnt_reg == START_PT) begin
          if (sample_bit == LINE_START) begin
            state_next = DATA;
            cnt_next   = RELOAD;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_reg == BIT_PT) begin
          shift_next[idx_reg] = sample_bit;
          cnt_next            = RELOAD;
          if (idx_reg == LAST_IDX) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cnt_reg == BIT_PT) begin
          par_flag_next = sample_bit ^ (^shift_reg) ^ ODD_BIT;
          cnt_next      = RELOAD;
          state_next    = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets an immediately following start bit be caught.
        if (cnt_reg == BIT_PT) begin
          state_next = IDLE;
          cnt_next   = '0;
          vld_next   = 1'b1;
          data_next  = shift_reg;
          perr_next  = par_flag_reg;
          ferr_next  = (sample_bit != LINE_IDLE);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign rx_data = data_reg;
  assign rx_vld  = vld_reg;
  assign par_err = perr_reg;
  assign frm_err = ferr_reg;
  assign rx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (434 clocks per bit, 8E1).
// Expected words go into a scoreboard queue as frames are driven; received words are popped and compared.
module tb_uart_rx;

  localparam int BIT  = 434;
  localparam int HALF = 217;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       par_err;
  logic       frm_err;
  logic       rx_busy;

  int total;
  int bad;
  int stray_flags;

  rec_t exp_q[$];
  rec_t obs_q[$];

  uart_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .par_err (par_err),
    .frm_err (frm_err),
    .rx_busy (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: records every valid pulse and any error flag raised outside one.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_vld === 1'b1) begin
        obs_q.push_back('{data: rx_data, pe: par_err, fe: frm_err});
      end else if (par_err !== 1'b0 || frm_err !== 1'b0) begin
        stray_flags++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    rx = v;
    for (int c = 0; c < BIT; c++) begin
      @(posedge clk);
      if (glitch) rx = (c == HALF) ? ~v : v;
    end
    rx = v;
  endtask

  // abort_bit >= 0 asserts reset halfway through that data bit and returns.
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                            input int abort_bit, input bit glitch);
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        rx = d[i];
        repeat (BIT / 2) @(posedge clk);
        rst_n = 1'b0;
        return;
      end
      drive_bit(d[i], glitch);
    end
    drive_bit((^d) ^ par_flip, glitch);
    drive_bit(stop, glitch);
  endtask

  task automatic collect(output rec_t got, output bit ok);
    got = '0;
    ok  = 1'b0;
    for (int i = 0; i < 3 * BIT && obs_q.size() == 0; i++) @(posedge clk);
    if (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      ok  = 1'b1;
    end
  endtask

  task automatic test_reset;
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(5);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
    total++; if (rx_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", rx_vld); end
    total++; if ({par_err, frm_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {par_err, frm_err}); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", rx_busy); end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic check_next(input string name);
    rec_t got, want;
    bit   ok;
    collect(got, ok);
    want = exp_q.pop_front();
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout got=no_rx_vld want=rx_vld", name);
    end else begin
      $display("rx %s: data=%h pe=%b fe=%b", name, got.data, got.pe, got.fe);
      total++; if (got.data !== want.data) begin bad++; $display("FAIL %s_data got=%h want=%h", name, got.data, want.data); end
      total++; if (got.pe !== want.pe) begin bad++; $display("FAIL %s_par_err got=%b want=%b", name, got.pe, want.pe); end
      total++; if (got.fe !== want.fe) begin bad++; $display("FAIL %s_frm_err got=%b want=%b", name, got.fe, want.fe); end
    end
  endtask

  task automatic test_clean;
    exp_q.push_back('{data: 8'hA5, pe: 1'b0, fe: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
    idle(50);
    check_next("clean_a5");
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL clean_count got=%0d extra want=0", obs_q.size()); end
  endtask

  task automatic test_parity;
    exp_q.push_back('{data: 8'hA5, pe: 1'b1, fe: 1'b0});
    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
    idle(50);
    check_next("parity_err");
  endtask

  task automatic test_break;
    exp_q.push_back('{data: 8'h3C, pe: 1'b0, fe: 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
    rx = 1'b0;
    check_next("break");
    idle(5000);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL break_retrigger got=%0d want=0", obs_q.size()); end
    rx = 1'b1;
    idle(30);
    exp_q.push_back('{data: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    idle(50);
    check_next("after_break");
  endtask

  task automatic test_glitch;
    @(posedge clk);
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(50);
    #1;
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_mid got=%b want=1", rx_busy); end
    idle(90);
    #1;
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", rx_busy); end
    idle(BIT);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL glitch_vld got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b0});
    exp_q.push_back('{data: 8'hFF, pe: 1'b0, fe: 1'b0});
    send_frame(8'h00, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 1'b0);
    idle(50);
    check_next("b2b_first");
    check_next("b2b_second");
  endtask

  task automatic test_reset_mid;
    send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midreset_data got=%h want=00", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", rx_busy); end
    idle(10);
    rx    = 1'b1;
    rst_n = 1'b1;
    idle(2 * BIT * 10);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL midreset_vld got=%0d want=0", obs_q.size()); end
    exp_q.push_back('{data: 8'h5A, pe: 1'b0, fe: 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
    idle(50);
    check_next("after_reset");
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority;
    exp_q.push_back('{data: 8'h5A, pe: 1'b0, fe: 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b1);
    idle(50);
    check_next("majority");
  endtask
`endif

  task automatic test_quiet_flags;
    total++; if (stray_flags != 0) begin bad++; $display("FAIL flags_without_vld got=%0d want=0", stray_flags); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    stray_flags = 0;
    rx          = 1'b1;
    rst_n       = 1'b1;
    test_reset;
    test_clean;
    test_parity;
    test_break;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_MAJORITY_EN
    test_majority;
`endif
    test_quiet_flags;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
